chip_test_sequencer: RTL and testbench
======================================

// Module: chip_test_sequencer
// PURPOSE
//   Schedules the per-chip tester blocks that share the single DUT socket.
//   Latches the user chip selection on a Run press and routes the socket pin bus to that tester only.
//   Pulses the selected tester's Run, waits for its Done (with optional watchdog) and latches the pass/fail verdict.
//   Sits between the board I/O (switches, button, socket pins) and the chip_74xx tester instances.
// PARAMETERS
//   NUM_CHIPS    4    number of tester instances sharing the socket
//   NPINS        16   socket pin count
//   SETTLE_CYC   4    cycles socket is driven by selected tester before its Run asserts (>=1)
//   TIMEOUT_CYC  64   max cycles in RUN before abort (used only with CHIP_TIMEOUT_EN)
// PORTS
//   Clk          in   1                clock
//   Reset        in   1                asynchronous reset, active-low
//   Run          in   1                start request, level; rising edge starts a test
//   Sel          in   $clog2(NUM_CHIPS) chip select (tester index)
//   Chip_Run     out  NUM_CHIPS        one-hot Run to testers
//   Chip_Done    in   NUM_CHIPS        tester Done flags
//   Chip_RSLT    in   NUM_CHIPS        tester pass(1)/fail(0)
//   Chip_Pin_O   in   NUM_CHIPS*NPINS  tester pin drive values, tester k at [k*NPINS +: NPINS]
//   Chip_Pin_OE  in   NUM_CHIPS*NPINS  tester pin output enables, same packing
//   Pin_O        out  NPINS            socket drive values
//   Pin_OE       out  NPINS            socket output enables (0 = hi-Z)
//   Busy         out  1                high in SETTLE and RUN
//   Done         out  1                high in DONE
//   RSLT         out  1                latched verdict, valid when Done=1
//   Err          out  1                invalid Sel or timeout, valid when Done=1
// BEHAVIOUR
//   Reset low (async): state=IDLE, sel_q=0, counters=0, Run edge detector primed (run_q=1). All outputs 0.
//   Edge detect: start = Run & ~run_q; run_q registered each cycle. Run held high through reset does not start a test.
//   IDLE: on start: if Sel<NUM_CHIPS, latch sel_q=Sel, cnt=0, -> SETTLE; else Err=1, RSLT=0 -> DONE.
//   SETTLE: Pin_O/Pin_OE = slice sel_q; Chip_Run=0; cnt++; after SETTLE_CYC cycles -> RUN (armed=0, cnt=0).
//   RUN: Chip_Run[sel_q]=1, others 0; pins from slice sel_q.
//     armed set once Chip_Done[sel_q]==0 is sampled; stale Done high at entry is ignored.
//     armed & Chip_Done[sel_q]: RSLT<=Chip_RSLT[sel_q], Err<=0 -> DONE (latency: Done high cycle after sample).
//   DONE: Done=1, Chip_Run=0, Pin_OE=0. RSLT/Err held. start -> same decision as IDLE (Done drops next cycle).
//   In any state other than IDLE/DONE: start, Sel changes, and Chip_Done/RSLT of unselected testers ignored.
//   Pin_OE=0 and Pin_O=0 in IDLE and DONE; no tester reaches the socket outside SETTLE/RUN.
//   Outputs Busy/Done/Chip_Run/Pin_* decoded from registered state + sel_q (glitch-free one-hot Chip_Run).
//   Reset mid-test: socket immediately hi-Z, Chip_Run=0, verdict discarded.
// CONFIGURATION
//   CHIP_TIMEOUT_EN defined: RUN counts cycles; if cnt reaches TIMEOUT_CYC-1 with no accepted Done ->
//     DONE with RSLT=0, Err=1. Done on the same cycle as timeout wins (normal verdict).
//   CHIP_TIMEOUT_EN undefined: no counter in RUN; waits indefinitely; Err only for invalid Sel.
// TESTING (NUM_CHIPS=3, NPINS=16, SETTLE_CYC=4, TIMEOUT_CYC=64)
//   Sel=1, Run 0->1; tester1 Done=1 RSLT=1 after 10 cycles -> Busy 4+10 cycles, Done=1 RSLT=1 Err=0, Chip_Run=3'b010 only in RUN.
//   Sel=2, Chip_Pin_OE slice2=16'h0F3C, slice0=16'hFFFF -> Pin_OE=16'h0F3C during SETTLE/RUN, 16'h0000 in IDLE/DONE.
//   Tester0 Done already high on entry, then low 1 cycle, then high RSLT=0 -> only second high accepted, RSLT=0.
//   Sel=3 (invalid), Run edge -> next cycle Done=1 Err=1 RSLT=0, Chip_Run never asserted.
//   CHIP_TIMEOUT_EN, tester never Done -> Done=1 Err=1 RSLT=0 exactly 64 cycles after RUN entry.
//   Reset low during RUN cycle 5 -> same cycle Pin_OE=0, Chip_Run=0; Run held high after release -> stays IDLE.

Source files
------------

// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer: schedules the per-chip tester blocks that share one DUT socket.
// A rising edge on Run latches the chip selection. The selected tester drives the socket
// for SETTLE_CYC cycles and then receives Run. The sequencer waits for that tester's Done
// and latches its pass/fail verdict.
// Optional feature: define CHIP_TIMEOUT_EN to abort a RUN that lasts TIMEOUT_CYC cycles.
module chip_test_sequencer #(
   parameter int NUM_CHIPS   = 4,
   parameter int NPINS       = 16,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 64,
   localparam int SEL_W      = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       Run,
   input  logic [SEL_W-1:0]           Sel,
   output logic [NUM_CHIPS-1:0]       Chip_Run,
   input  logic [NUM_CHIPS-1:0]       Chip_Done,
   input  logic [NUM_CHIPS-1:0]       Chip_RSLT,
   input  logic [NUM_CHIPS*NPINS-1:0] Chip_Pin_O,
   input  logic [NUM_CHIPS*NPINS-1:0] Chip_Pin_OE,
   output logic [NPINS-1:0]           Pin_O,
   output logic [NPINS-1:0]           Pin_OE,
   output logic                       Busy,
   output logic                       Done,
   output logic                       RSLT,
   output logic                       Err
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

`ifdef CHIP_TIMEOUT_EN
   localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
`else
   localparam int CNT_MAX = SETTLE_CYC;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             armed_q, armed_d;
   logic             rslt_q, rslt_d;
   logic             err_q, err_d;
   logic             run_q;
   logic             start;
   logic             sel_ok;

   assign start  = Run & ~run_q;
   assign sel_ok = (int'(Sel) < NUM_CHIPS);

   // State register, latched verdict and Run edge detector.
   // run_q comes out of reset high, so a Run held high across reset cannot start a test.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         armed_q <= 1'b0;
         rslt_q  <= 1'b0;
         err_q   <= 1'b0;
         run_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         armed_q <= armed_d;
         rslt_q  <= rslt_d;
         err_q   <= err_d;
         run_q   <= Run;
      end
   end

   // Next-state logic for test scheduling, the Done qualification and the verdict.
   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      armed_d = armed_q;
      rslt_d  = rslt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (sel_ok) begin
                  sel_d   = Sel;
                  cnt_d   = '0;
                  state_d = S_SETTLE;
               end else begin
                  err_d   = 1'b1;
                  rslt_d  = 1'b0;
                  state_d = S_DONE;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               cnt_d   = '0;
               armed_d = 1'b0;
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            // A Done already high at RUN entry is stale. Accept Done only after it has been seen low.
            if (!Chip_Done[sel_q]) armed_d = 1'b1;
            if (armed_q && Chip_Done[sel_q]) begin
               rslt_d  = Chip_RSLT[sel_q];
               err_d   = 1'b0;
               state_d = S_DONE;
            end
`ifdef CHIP_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               rslt_d  = 1'b0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from registered state only; the socket is hi-Z outside SETTLE/RUN.
   always_comb begin
      Busy     = (state_q == S_SETTLE) || (state_q == S_RUN);
      Done     = (state_q == S_DONE);
      RSLT     = rslt_q;
      Err      = err_q;
      Chip_Run = '0;
      Pin_O    = '0;
      Pin_OE   = '0;
      if (state_q == S_RUN) Chip_Run = NUM_CHIPS'(1) << sel_q;
      if (Busy) begin
         Pin_O  = Chip_Pin_O[sel_q*NPINS +: NPINS];
         Pin_OE = Chip_Pin_OE[sel_q*NPINS +: NPINS];
      end
   end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Testbench for chip_test_sequencer (NUM_CHIPS=3). A behavioural model tracks each test by its
// age in cycles since the start edge, and a compare process checks every output on each
// falling clock edge. Directed scenarios pin the model with hand-computed expectations.
// Randomized traffic follows. Define CHIP_TIMEOUT_EN to include the watchdog scenario.
module tb_chip_test_sequencer;
   localparam int NUM_CHIPS   = 3;
   localparam int NPINS       = 16;
   localparam int SETTLE_CYC  = 4;
   localparam int TIMEOUT_CYC = 64;
`ifdef CHIP_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Run = 1'b1;
   logic [1:0]  Sel = '0;
   logic [2:0]  Chip_Run;
   logic [2:0]  Chip_Done = '0;
   logic [2:0]  Chip_RSLT = '0;
   logic [47:0] Chip_Pin_O = '0;
   logic [47:0] Chip_Pin_OE = '0;
   logic [15:0] Pin_O, Pin_OE;
   logic        Busy, Done, RSLT, Err;

   int passed = 0;
   int total  = 0;

   chip_test_sequencer #(
      .NUM_CHIPS(NUM_CHIPS), .NPINS(NPINS), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Sel(Sel),
      .Chip_Run(Chip_Run), .Chip_Done(Chip_Done), .Chip_RSLT(Chip_RSLT),
      .Chip_Pin_O(Chip_Pin_O), .Chip_Pin_OE(Chip_Pin_OE),
      .Pin_O(Pin_O), .Pin_OE(Pin_OE),
      .Busy(Busy), .Done(Done), .RSLT(RSLT), .Err(Err)
   );

   initial forever #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
      else passed++;
   endtask

   // ---------------- behavioural model ----------------
   // A test is "active" from its start edge. Its first SETTLE_CYC cycles drive the socket only.
   // Later cycles are Run cycles.
   bit m_active = 1'b0;
   bit m_done   = 1'b0;
   bit m_run_q  = 1'b1;
   bit m_seen_low = 1'b0;
   bit m_rslt = 1'b0;
   bit m_err  = 1'b0;
   int m_age  = 0;
   int m_sel  = 0;

   task automatic model_step();
      bit start;
      if (!Reset) begin
         m_active = 1'b0; m_done = 1'b0; m_run_q = 1'b1;
         m_rslt = 1'b0; m_err = 1'b0; m_age = 0;
         return;
      end
      start   = Run && !m_run_q;
      m_run_q = Run;
      if (!m_active) begin
         if (start) begin
            if (int'(Sel) < NUM_CHIPS) begin
               m_active = 1'b1; m_done = 1'b0; m_age = 0;
               m_sel = int'(Sel); m_seen_low = 1'b0;
            end else begin
               m_done = 1'b1; m_err = 1'b1; m_rslt = 1'b0;
            end
         end
      end else if (m_age < SETTLE_CYC) begin
         m_age++;
      end else if (m_seen_low && Chip_Done[m_sel]) begin
         m_active = 1'b0; m_done = 1'b1; m_rslt = Chip_RSLT[m_sel]; m_err = 1'b0;
      end else if (TIMEOUT_EN && (m_age - SETTLE_CYC == TIMEOUT_CYC - 1)) begin
         m_active = 1'b0; m_done = 1'b1; m_rslt = 1'b0; m_err = 1'b1;
      end else begin
         if (!Chip_Done[m_sel]) m_seen_low = 1'b1;
         m_age++;
      end
   endtask

   initial forever begin
      @(posedge Clk or negedge Reset);
      model_step();
   end

   // Compare process: every output, every falling edge.
   initial forever begin
      logic [2:0]  exp_run;
      logic [15:0] exp_o, exp_oe;
      @(negedge Clk);
      exp_run = (m_active && m_age >= SETTLE_CYC) ? 3'(1 << m_sel) : 3'b000;
      exp_o   = m_active ? Chip_Pin_O[m_sel*NPINS +: NPINS] : 16'h0000;
      exp_oe  = m_active ? Chip_Pin_OE[m_sel*NPINS +: NPINS] : 16'h0000;
      check("busy", 48'(Busy), 48'(m_active));
      check("done", 48'(Done), 48'(m_done));
      check("chip_run", 48'(Chip_Run), 48'(exp_run));
      check("pin_o", 48'(Pin_O), 48'(exp_o));
      check("pin_oe", 48'(Pin_OE), 48'(exp_oe));
      if (m_done || !Reset) begin
         check("rslt", 48'(RSLT), 48'(m_rslt));
         check("err", 48'(Err), 48'(m_err));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int busy_cnt;
      // Reset with Run held high, then release mid-cycle: no test may start.
      repeat (3) step();
      check("rst_busy", 48'(Busy), 48'(0));
      check("rst_done", 48'(Done), 48'(0));
      check("rst_chip_run", 48'(Chip_Run), 48'(0));
      check("rst_pin_oe", 48'(Pin_OE), 48'(0));
      check("rst_rslt", 48'(RSLT), 48'(0));
      check("rst_err", 48'(Err), 48'(0));
      #2 Reset = 1'b1;
      repeat (5) step();
      check("run_held_no_start", 48'(Busy), 48'(0));

      // Tester 1 passes; Done raised in its 10th Run cycle -> Busy 4+10 cycles.
      Run = 1'b0; step();
      Sel = 2'd1; Chip_Done = '0; Chip_RSLT = 3'b010;
      Chip_Pin_O = 48'h1234_5678_9ABC; Chip_Pin_OE = 48'hF00F_0FF0_00FF;
      Run = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (i == 13) Chip_Done[1] = 1'b1;
         @(negedge Clk);
         if (Busy) busy_cnt++;
      end
      check("t1_busy_cycles", 48'(busy_cnt), 48'(14));
      check("t1_done", 48'(Done), 48'(1));
      check("t1_rslt", 48'(RSLT), 48'(1));
      check("t1_err", 48'(Err), 48'(0));
      Chip_Done = '0; Run = 1'b0;

      // Tester 2 pin enables reach the socket only during SETTLE/RUN.
      step();
      Sel = 2'd2; Chip_Pin_OE = {16'h0F3C, 16'hA5A5, 16'hFFFF};
      Run = 1'b1;
      step();
      @(negedge Clk);
      check("t2_oe_settle", 48'(Pin_OE), 48'h0F3C);
      repeat (4) step();
      @(negedge Clk);
      check("t2_oe_run", 48'(Pin_OE), 48'h0F3C);
      check("t2_chip_run", 48'(Chip_Run), 48'(3'b100));
      step();
      Chip_Done[2] = 1'b1; Chip_RSLT[2] = 1'b0;
      repeat (2) step();
      @(negedge Clk);
      check("t2_oe_done", 48'(Pin_OE), 48'h0000);
      check("t2_rslt", 48'(RSLT), 48'(0));
      Chip_Done = '0; Run = 1'b0;

      // Tester 0: stale Done high at RUN entry is ignored; only the second high counts.
      Chip_Done[0] = 1'b1; Chip_RSLT[0] = 1'b1; Sel = 2'd0;
      step();
      Run = 1'b1;
      repeat (6) step();
      Chip_Done[0] = 1'b0;
      @(negedge Clk);
      check("t0_stale_ignored", 48'(Busy), 48'(1));
      step();
      Chip_Done[0] = 1'b1; Chip_RSLT[0] = 1'b0;
      step();
      @(negedge Clk);
      check("t0_done", 48'(Done), 48'(1));
      check("t0_rslt", 48'(RSLT), 48'(0));
      Chip_Done = '0; Run = 1'b0;

      // Invalid selection: Done with Err the very next cycle.
      step();
      Sel = 2'd3; Run = 1'b1;
      step();
      @(negedge Clk);
      check("inv_done", 48'(Done), 48'(1));
      check("inv_err", 48'(Err), 48'(1));
      check("inv_rslt", 48'(RSLT), 48'(0));
      Run = 1'b0;

`ifdef CHIP_TIMEOUT_EN
      // Tester never finishes: abort exactly TIMEOUT_CYC cycles after RUN entry.
      step();
      Sel = 2'd1; Chip_Done = '0; Run = 1'b1;
      repeat (68) step();
      @(negedge Clk);
      check("to_not_yet", 48'(Done), 48'(0));
      step();
      @(negedge Clk);
      check("to_done", 48'(Done), 48'(1));
      check("to_err", 48'(Err), 48'(1));
      check("to_rslt", 48'(RSLT), 48'(0));
      Run = 1'b0;
`endif

      // Reset during RUN cycle 5: the socket is released at once, and a held Run does not restart.
      step();
      Sel = 2'd0; Chip_Done = '0; Chip_Pin_OE = 48'hFFFF_FFFF_FFFF; Run = 1'b1;
      repeat (10) step();
      check("mid_chip_run", 48'(Chip_Run), 48'(3'b001));
      #1 Reset = 1'b0;
      #1;
      check("mid_rst_pin_oe", 48'(Pin_OE), 48'h0000);
      check("mid_rst_chip_run", 48'(Chip_Run), 48'(0));
      repeat (2) step();
      #2 Reset = 1'b1;
      repeat (5) step();
      @(negedge Clk);
      check("post_rst_idle", 48'(Busy), 48'(0));
      check("post_rst_done", 48'(Done), 48'(0));

      // Randomized traffic: glitchy Run, changing Sel, random tester flags and pins.
      Run = 1'b0;
      step();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) Run = ~Run;
         if ($urandom_range(0, 3) == 0) Sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) Chip_Done = 3'($urandom);
         Chip_RSLT   = 3'($urandom);
         Chip_Pin_O  = 48'({$urandom(), $urandom()});
         Chip_Pin_OE = 48'({$urandom(), $urandom()});
         step();
      end
      @(negedge Clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
